decode_stage: RTL and testbench
===============================

# decode_stage

Registered RV32I decode stage between fetch and execute. It replaces the purely combinational decoder with a pipeline register and valid/ready handshakes on both sides. It adds a load-use hazard scoreboard, flush, illegal-opcode detection and a 4-bit ALU control. Each accepted instruction appears decoded on the outputs one cycle later and is held until execute accepts it.

## Interface
Parameters:
- PC_W, 32, width of the pc carried alongside the instruction.
- LOAD_LAT, 1, number of cycles after a load leaves this stage during which its rd is unavailable; legal range 1..4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  fetch offers i_inst/i_pc.
- o_ready  out  1  stage accepts this cycle (combinational).
- i_inst  in  32  instruction word.
- i_pc  in  PC_W  instruction address.
- i_flush  in  1  discard held and offered instruction (branch redirect).
- o_valid  out  1  decoded instruction held on outputs.
- i_ready  in  1  execute accepts this cycle.
- o_pc  out  PC_W  pc of held instruction.
- o_rs1, o_rs2, o_rd  out  5 each  register fields (raw bit slices).
- o_funct3  out  3  inst[14:12].
- o_ALUCtrl  out  4  ALU operation.
- o_imm  out  32  sign-extended immediate.
- o_regWrite, o_ALUSrc, o_ALUSrcPC, o_branch, o_jump, o_mem2Reg, o_memRead, o_memWrite  out  1 each  control.
- o_illegal  out  1  unsupported opcode.
- o_stall  out  1  hazard blocking acceptance this cycle.

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Any other opcode sets illegal=1 and forces regWrite, memRead, memWrite, branch and jump to 0. The instruction still passes downstream.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All sign-extended from bit 31; R-type imm = 0.
- ALUCtrl: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010.
  - OP/OP-IMM: from funct3; bit30 selects SUB (OP only) and SRA.
  - LOAD, STORE, AUIPC, JAL, JALR: ADD. LUI: PASSB.
  - BEQ/BNE: SUB. BLT/BGE: SLT. BLTU/BGEU: SLTU.
- Control:
  - ALUSrc=1 for all except OP and BRANCH.
  - ALUSrcPC=1 for AUIPC, JAL.
  - jump=1 for JAL, JALR.
  - mem2Reg=memRead=1 for LOAD.
  - regWrite=1 for LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM, forced 0 when rd==0.
- Register use:
  - rs1 is used by all except LUI, AUIPC, JAL.
  - rs2 is used by OP, STORE, BRANCH.
  - An unused or x0 source never causes a hazard.
- Hazard (combinational on i_inst): a used source equals rd of either
  - the held instruction, when o_valid&&o_memRead, or
  - any valid scoreboard entry.
- Scoreboard:
  - LOAD_LAT entries of {v, rd}, shifted every clock.
  - Entry 0 is loaded with v=1 when o_valid&&i_ready&&o_memRead&&o_rd!=0, otherwise v=0.
  - The oldest entry is discarded.
  - i_flush does not clear it.
- o_stall = i_valid && hazard && !i_flush.
- o_ready = !i_flush && !o_stall && (!o_valid || i_ready).
- Output register:
  - i_flush: o_valid<=0.
  - Else on i_valid&&o_ready: load decoded fields, o_valid<=1.
  - Else if i_ready: o_valid<=0.
  - Otherwise hold all outputs stable.

## Timing
- Latency: instruction accepted at edge t is on outputs from t to t+1. Throughput is 1/cycle with no hazards.
- Reset (asynchronous, any time): o_valid=0, all registered outputs 0, scoreboard cleared. o_ready=1 and o_stall=0 while inputs idle.
- Load-use: a load handed off at the handshake in cycle t blocks a dependent instruction in cycles t..t+LOAD_LAT.
  - Cycle t blocks because the load is still held.
  - Cycles t+1..t+LOAD_LAT block via the scoreboard.
  - Acceptance occurs in cycle t+LOAD_LAT+1 at earliest.
- Back-pressure with i_ready=0: held outputs do not change; o_ready=0 while o_valid=1.
- Simultaneous events:
  - flush + i_valid: nothing accepted; o_valid=0 next cycle.
  - flush + held load with i_ready=1: the load is handed off and enters the scoreboard.
- Reset mid-stall releases the stall immediately.

## Test plan
- Reset, then offer addi x1,x0,5 (0x00500093) with i_ready=1 → next cycle:
  - o_valid=1, o_rd=1, o_rs1=0, o_imm=5, ALUCtrl=0000, ALUSrc=1, regWrite=1.
  - o_ready stays 1.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3), LOAD_LAT=1, i_ready=1:
  - o_stall=1 for exactly 2 cycles.
  - The add is accepted in the third cycle; then o_ALUCtrl=0000, o_rs1=2, o_rs2=1.
- sw x2,4(x1) (0x0020A223) → o_imm=4, memWrite=1, regWrite=0, ALUSrc=1. Then beq x1,x2,-4 (0xFE208EE3) → o_imm=0xFFFFFFFC, branch=1, ALUCtrl=0001, ALUSrc=0.
- lui x5,0x12345 (0x123452B7) held with i_ready=0 for 3 cycles → outputs stable, o_ready=0, o_imm=0x12345000, ALUCtrl=1010. Then i_flush=1 → o_valid=0 next cycle.
- Illegal-opcode and rd=x0 checks:
  - 0x00000000 → o_illegal=1, regWrite=memRead=memWrite=branch=jump=0.
  - addi x0,x0,0 (0x00000013) → regWrite=0.
- LOAD_LAT=3: lw x2 then a dependent add, with i_ready=1 → stall lasts 4 cycles. Assert i_rst mid-stall → o_valid=0 and o_stall=0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I decode stage sitting between fetch and execute.
//
// An instruction offered by fetch (i_valid) is decoded combinationally. It is
// captured into the output register when the stage is ready (o_ready). It is
// then held on the o_* outputs until execute takes it (i_ready).
//
// A small shift-register scoreboard remembers the destination registers of
// loads that recently left this stage. Any instruction that reads one of those
// registers is stalled until the load data can be forwarded downstream.
//
// Ports
//   i_clk, i_rst     clock (rising edge), asynchronous active-high reset
//   i_valid/o_ready  fetch-side handshake; i_inst/i_pc are the offered payload
//   i_flush          branch redirect: drop the held and the offered instruction
//   o_valid/i_ready  execute-side handshake; o_* are the held decoded fields
//   o_rs1/o_rs2/o_rd raw register fields; o_funct3 = inst[14:12]
//   o_ALUCtrl        4-bit ALU operation; o_imm sign-extended immediate
//   o_regWrite .. o_memWrite  datapath control bits
//   o_illegal        opcode outside the supported RV32I base set
//   o_stall          load-use hazard is blocking acceptance this cycle
//
// Parameters
//   PC_W      width of the pc carried alongside the instruction
//   LOAD_LAT  cycles after a load leaves this stage during which its rd is
//             not yet available (1..4)
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int PC_W     = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [2:0]      o_funct3,
    output logic [3:0]      o_ALUCtrl,
    output logic [31:0]     o_imm,
    output logic            o_regWrite,
    output logic            o_ALUSrc,
    output logic            o_ALUSrcPC,
    output logic            o_branch,
    output logic            o_jump,
    output logic            o_mem2Reg,
    output logic            o_memRead,
    output logic            o_memWrite,
    output logic            o_illegal,
    output logic            o_stall
);

    // -------------------------------------------------------------------------
    // Opcode and ALU operation encodings
    // -------------------------------------------------------------------------
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // Arithmetic/logic op from funct3. inst[30] picks SRA over SRL. It picks
    // SUB over ADD only for register-register ops, because in OP-IMM that bit
    // belongs to the immediate.
    function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                            input logic       bit30,
                                            input logic       allow_sub);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (allow_sub && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch compare op: equality tests subtract, ordered tests use set-less-than.
    function automatic logic [3:0] branch_op(input logic [2:0] f3);
        logic [3:0] op;
        op = ALU_SUB;
        case (f3)
            3'b100, 3'b101: op = ALU_SLT;
            3'b110, 3'b111: op = ALU_SLTU;
            default:        op = ALU_SUB;
        endcase
        return op;
    endfunction

    // -------------------------------------------------------------------------
    // Field extraction and immediates of the offered instruction
    // -------------------------------------------------------------------------
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign dec_opcode = i_inst[6:0];
    assign dec_rd     = i_inst[11:7];
    assign dec_funct3 = i_inst[14:12];
    assign dec_rs1    = i_inst[19:15];
    assign dec_rs2    = i_inst[24:20];

    assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                    i_inst[11:8], 1'b0};
    assign imm_u = {i_inst[31:12], 12'b0};
    assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                    i_inst[30:21], 1'b0};

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_ctrl;
    logic        dec_alu_src;
    logic        dec_alu_src_pc;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_mem2reg;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_writes_rd;
    logic        dec_reg_write;
    logic        dec_illegal;
    logic        dec_use_rs1;
    logic        dec_use_rs2;

    always_comb begin
        dec_imm        = 32'd0;
        dec_alu_ctrl   = ALU_ADD;
        dec_alu_src    = 1'b1;
        dec_alu_src_pc = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_mem2reg    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_writes_rd  = 1'b0;
        dec_illegal    = 1'b0;
        dec_use_rs1    = 1'b1;
        dec_use_rs2    = 1'b0;
        case (dec_opcode)
            OPC_LUI: begin
                dec_imm       = imm_u;
                dec_alu_ctrl  = ALU_PASSB;
                dec_writes_rd = 1'b1;
                dec_use_rs1   = 1'b0;
            end
            OPC_AUIPC: begin
                dec_imm        = imm_u;
                dec_alu_src_pc = 1'b1;
                dec_writes_rd  = 1'b1;
                dec_use_rs1    = 1'b0;
            end
            OPC_JAL: begin
                dec_imm        = imm_j;
                dec_alu_src_pc = 1'b1;
                dec_jump       = 1'b1;
                dec_writes_rd  = 1'b1;
                dec_use_rs1    = 1'b0;
            end
            OPC_JALR: begin
                dec_imm       = imm_i;
                dec_jump      = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm      = imm_b;
                dec_alu_ctrl = branch_op(dec_funct3);
                dec_alu_src  = 1'b0;
                dec_branch   = 1'b1;
                dec_use_rs2  = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm       = imm_i;
                dec_mem2reg   = 1'b1;
                dec_mem_read  = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec_imm       = imm_s;
                dec_mem_write = 1'b1;
                dec_use_rs2   = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm       = imm_i;
                dec_alu_ctrl  = arith_op(dec_funct3, i_inst[30], 1'b0);
                dec_writes_rd = 1'b1;
            end
            OPC_OP: begin
                dec_alu_ctrl  = arith_op(dec_funct3, i_inst[30], 1'b1);
                dec_alu_src   = 1'b0;
                dec_writes_rd = 1'b1;
                dec_use_rs2   = 1'b1;
            end
            default: begin
                // Unknown opcode: passed downstream flagged, with every
                // side-effecting control left at 0 so it cannot alter state.
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Writes to x0 are architecturally discarded; suppress them here so that
    // execute and writeback never need to special-case rd==0.
    assign dec_reg_write = dec_writes_rd && (dec_rd != 5'd0);

    // -------------------------------------------------------------------------
    // Load-use scoreboard
    // Entry 0 records a load handed to execute on this edge. Entries age by one
    // slot every clock, whatever the pipeline does, because a load that has
    // left this stage keeps progressing downstream regardless of stalls or
    // flushes here.
    // -------------------------------------------------------------------------
    logic                     sb_push;
    logic [LOAD_LAT-1:0]      sb_v_reg;
    logic [LOAD_LAT-1:0][4:0] sb_rd_reg;

    assign sb_push = o_valid && i_ready && o_memRead && (o_rd != 5'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sb_v_reg  <= '0;
            sb_rd_reg <= '0;
        end else begin
            sb_v_reg[0]  <= sb_push;
            sb_rd_reg[0] <= o_rd;
            for (int i = 1; i < LOAD_LAT; i++) begin
                sb_v_reg[i]  <= sb_v_reg[i-1];
                sb_rd_reg[i] <= sb_rd_reg[i-1];
            end
        end
    end

    // Per-entry match of each source register against the scoreboard.
    logic [LOAD_LAT-1:0] sb_hit_rs1;
    logic [LOAD_LAT-1:0] sb_hit_rs2;

    generate
        for (genvar gi = 0; gi < LOAD_LAT; gi++) begin : gen_sb_hit
            assign sb_hit_rs1[gi] = sb_v_reg[gi] && (sb_rd_reg[gi] == dec_rs1);
            assign sb_hit_rs2[gi] = sb_v_reg[gi] && (sb_rd_reg[gi] == dec_rs2);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Hazard detection
    // A load still held in the output register counts as well: its data is
    // even further away than any load already in the scoreboard.
    // -------------------------------------------------------------------------
    logic held_load;
    logic rs1_hazard;
    logic rs2_hazard;
    logic hazard;

    assign held_load  = o_valid && o_memRead;
    assign rs1_hazard = dec_use_rs1 && (dec_rs1 != 5'd0) &&
                        ((held_load && (o_rd == dec_rs1)) || (|sb_hit_rs1));
    assign rs2_hazard = dec_use_rs2 && (dec_rs2 != 5'd0) &&
                        ((held_load && (o_rd == dec_rs2)) || (|sb_hit_rs2));
    assign hazard     = rs1_hazard || rs2_hazard;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign o_stall = i_valid && hazard && !i_flush;
    assign o_ready = !i_flush && !o_stall && (!o_valid || i_ready);

    // -------------------------------------------------------------------------
    // Output register
    // Payload fields change only when a new instruction is captured, so they
    // stay stable under back-pressure and after a flush.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_rs1      <= 5'd0;
            o_rs2      <= 5'd0;
            o_rd       <= 5'd0;
            o_funct3   <= 3'd0;
            o_ALUCtrl  <= 4'd0;
            o_imm      <= 32'd0;
            o_regWrite <= 1'b0;
            o_ALUSrc   <= 1'b0;
            o_ALUSrcPC <= 1'b0;
            o_branch   <= 1'b0;
            o_jump     <= 1'b0;
            o_mem2Reg  <= 1'b0;
            o_memRead  <= 1'b0;
            o_memWrite <= 1'b0;
            o_illegal  <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (i_valid && o_ready) begin
            o_valid    <= 1'b1;
            o_pc       <= i_pc;
            o_rs1      <= dec_rs1;
            o_rs2      <= dec_rs2;
            o_rd       <= dec_rd;
            o_funct3   <= dec_funct3;
            o_ALUCtrl  <= dec_alu_ctrl;
            o_imm      <= dec_imm;
            o_regWrite <= dec_reg_write;
            o_ALUSrc   <= dec_alu_src;
            o_ALUSrcPC <= dec_alu_src_pc;
            o_branch   <= dec_branch;
            o_jump     <= dec_jump;
            o_mem2Reg  <= dec_mem2reg;
            o_memRead  <= dec_mem_read;
            o_memWrite <= dec_mem_write;
            o_illegal  <= dec_illegal;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage. Two instances share clock and reset:
// dut1 (LOAD_LAT=1) covers decode, handshake, back-pressure and flush, and
// dut3 (LOAD_LAT=3) covers the longer load-use stall and reset during a stall.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam logic [31:0] INST_ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] INST_LW   = 32'h0000A103;  // lw   x2,0(x1)
    localparam logic [31:0] INST_ADD  = 32'h001101B3;  // add  x3,x2,x1
    localparam logic [31:0] INST_SW   = 32'h0020A223;  // sw   x2,4(x1)
    localparam logic [31:0] INST_BEQ  = 32'hFE208EE3;  // beq  x1,x2,-4
    localparam logic [31:0] INST_LUI  = 32'h123452B7;  // lui  x5,0x12345
    localparam logic [31:0] INST_ZERO = 32'h00000000;  // illegal
    localparam logic [31:0] INST_NOP  = 32'h00000013;  // addi x0,x0,0
    localparam logic [31:0] INST_JAL  = 32'h008000EF;  // jal  x1,8

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // dut1 signals
    logic        v1, f1, r1, rdy1, ov1;
    logic [31:0] inst1, pc1, opc1, imm1;
    logic [4:0]  rs1_1, rs2_1, rd_1;
    logic [2:0]  f3_1;
    logic [3:0]  alu1;
    logic        rw1, as1, apc1, br1, jp1, m2r1, mr1, mw1, ill1, st1;

    // dut3 signals
    logic        v3, f3i, r3, rdy3, ov3;
    logic [31:0] inst3, pc3, opc3, imm3;
    logic [4:0]  rs1_3, rs2_3, rd_3;
    logic [2:0]  f3_3;
    logic [3:0]  alu3;
    logic        rw3, as3, apc3, br3, jp3, m2r3, mr3, mw3, ill3, st3;

    decode_stage #(.PC_W(32), .LOAD_LAT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(rdy1),
        .i_inst(inst1), .i_pc(pc1), .i_flush(f1), .o_valid(ov1),
        .i_ready(r1), .o_pc(opc1), .o_rs1(rs1_1), .o_rs2(rs2_1),
        .o_rd(rd_1), .o_funct3(f3_1), .o_ALUCtrl(alu1), .o_imm(imm1),
        .o_regWrite(rw1), .o_ALUSrc(as1), .o_ALUSrcPC(apc1),
        .o_branch(br1), .o_jump(jp1), .o_mem2Reg(m2r1),
        .o_memRead(mr1), .o_memWrite(mw1), .o_illegal(ill1),
        .o_stall(st1)
    );

    decode_stage #(.PC_W(32), .LOAD_LAT(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_valid(v3), .o_ready(rdy3),
        .i_inst(inst3), .i_pc(pc3), .i_flush(f3i), .o_valid(ov3),
        .i_ready(r3), .o_pc(opc3), .o_rs1(rs1_3), .o_rs2(rs2_3),
        .o_rd(rd_3), .o_funct3(f3_3), .o_ALUCtrl(alu3), .o_imm(imm3),
        .o_regWrite(rw3), .o_ALUSrc(as3), .o_ALUSrcPC(apc3),
        .o_branch(br3), .o_jump(jp3), .o_mem2Reg(m2r3),
        .o_memRead(mr3), .o_memWrite(mw3), .o_illegal(ill3),
        .o_stall(st3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction to dut1 for a single edge; it must be accepted.
    task automatic accept1(input logic [31:0] inst, input logic [31:0] pc);
        v1 = 1'b1; inst1 = inst; pc1 = pc;
        #1;
        check("dut1 ready before accept", rdy1, 1);
        tick();
        v1 = 1'b0;
        $display("[TB] dut1 accept pc=%08h inst=%08h", pc, inst);
    endtask

    task automatic accept3(input logic [31:0] inst, input logic [31:0] pc);
        v3 = 1'b1; inst3 = inst; pc3 = pc;
        #1;
        check("dut3 ready before accept", rdy3, 1);
        tick();
        v3 = 1'b0;
        $display("[TB] dut3 accept pc=%08h inst=%08h", pc, inst);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        v1 = 1'b0; f1 = 1'b0; r1 = 1'b1; inst1 = '0; pc1 = '0;
        v3 = 1'b0; f3i = 1'b0; r3 = 1'b1; inst3 = '0; pc3 = '0;
        tick();
        tick();

        // ---- reset state ----
        check("rst o_valid", ov1, 0);
        check("rst o_rd", rd_1, 0);
        check("rst o_imm", imm1, 0);
        check("rst o_regWrite", rw1, 0);
        check("rst o_ALUSrc", as1, 0);
        check("rst o_ready", rdy1, 1);
        check("rst o_stall", st1, 0);
        rst = 1'b0;
        tick();

        // ---- addi x1,x0,5 ----
        accept1(INST_ADDI, 32'h100);
        check("addi o_valid", ov1, 1);
        check("addi o_pc", opc1, 32'h100);
        check("addi o_rd", rd_1, 1);
        check("addi o_rs1", rs1_1, 0);
        check("addi o_imm", imm1, 5);
        check("addi o_ALUCtrl", alu1, 4'b0000);
        check("addi o_ALUSrc", as1, 1);
        check("addi o_regWrite", rw1, 1);
        check("addi o_ready", rdy1, 1);

        // ---- lw x2 then dependent add, LOAD_LAT=1 ----
        accept1(INST_LW, 32'h104);
        check("lw o_memRead", mr1, 1);
        check("lw o_mem2Reg", m2r1, 1);
        check("lw o_rd", rd_1, 2);
        v1 = 1'b1; inst1 = INST_ADD; pc1 = 32'h108;
        #1;
        check("lu1 stall on held load", st1, 1);
        check("lu1 ready low", rdy1, 0);
        n = 0;
        while (st1 && n < 10) begin
            tick();
            n++;
        end
        check("lu1 stall cycles", n, 2);
        check("lu1 ready after stall", rdy1, 1);
        tick();
        v1 = 1'b0;
        $display("[TB] dut1 accept pc=%08h inst=%08h", 32'h108, INST_ADD);
        check("add o_valid", ov1, 1);
        check("add o_ALUCtrl", alu1, 4'b0000);
        check("add o_rs1", rs1_1, 2);
        check("add o_rs2", rs2_1, 1);
        check("add o_rd", rd_1, 3);
        check("add o_ALUSrc", as1, 0);

        // ---- sw, beq ----
        accept1(INST_SW, 32'h10C);
        check("sw o_imm", imm1, 4);
        check("sw o_memWrite", mw1, 1);
        check("sw o_regWrite", rw1, 0);
        check("sw o_ALUSrc", as1, 1);
        accept1(INST_BEQ, 32'h110);
        check("beq o_imm", imm1, 32'hFFFFFFFC);
        check("beq o_branch", br1, 1);
        check("beq o_ALUCtrl", alu1, 4'b0001);
        check("beq o_ALUSrc", as1, 0);
        check("beq o_regWrite", rw1, 0);

        // ---- lui held under back-pressure, then flushed ----
        accept1(INST_LUI, 32'h114);
        r1 = 1'b0; v1 = 1'b1; inst1 = INST_NOP; pc1 = 32'h118;
        #1;
        check("bp o_ready", rdy1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp o_valid", ov1, 1);
            check("bp o_imm", imm1, 32'h12345000);
            check("bp o_ALUCtrl", alu1, 4'b1010);
            check("bp o_rd", rd_1, 5);
            check("bp o_pc", opc1, 32'h114);
            check("bp o_ready", rdy1, 0);
        end
        f1 = 1'b1;
        #1;
        check("flush o_ready", rdy1, 0);
        tick();
        f1 = 1'b0; v1 = 1'b0; r1 = 1'b1;
        check("flush o_valid", ov1, 0);
        check("flush o_pc unchanged", opc1, 32'h114);

        // ---- illegal opcode, rd=x0, jal ----
        accept1(INST_ZERO, 32'h200);
        check("ill o_valid", ov1, 1);
        check("ill o_illegal", ill1, 1);
        check("ill ctrl", {27'd0, rw1, mr1, mw1, br1, jp1}, 0);
        accept1(INST_NOP, 32'h204);
        check("nop o_illegal", ill1, 0);
        check("nop o_regWrite", rw1, 0);
        check("nop o_ALUSrc", as1, 1);
        accept1(INST_JAL, 32'h208);
        check("jal o_imm", imm1, 8);
        check("jal o_jump", jp1, 1);
        check("jal o_ALUSrcPC", apc1, 1);
        check("jal o_regWrite", rw1, 1);

        // ---- LOAD_LAT=3 load-use ----
        accept3(INST_LW, 32'h300);
        v3 = 1'b1; inst3 = INST_ADD; pc3 = 32'h304;
        #1;
        n = 0;
        while (st3 && n < 10) begin
            tick();
            n++;
        end
        check("lu3 stall cycles", n, 4);
        check("lu3 ready after stall", rdy3, 1);
        tick();
        v3 = 1'b0;
        $display("[TB] dut3 accept pc=%08h inst=%08h", 32'h304, INST_ADD);
        check("lu3 add o_valid", ov3, 1);
        check("lu3 add o_rs1", rs1_3, 2);

        // ---- reset during a scoreboard stall ----
        accept3(INST_LW, 32'h308);
        v3 = 1'b1; inst3 = INST_ADD; pc3 = 32'h30C;
        #1;
        check("rs held-load stall", st3, 1);
        tick();
        check("rs scoreboard stall", st3, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rs o_stall", st3, 0);
        check("rs o_valid", ov3, 0);
        check("rs o_ready", rdy3, 1);
        #1;
        rst = 1'b0;
        tick();
        check("rs stall after release", st3, 0);
        v3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
